// File: rtl/branch_resolve.sv
// Resolves RV32I conditional branches, JAL and JALR into a registered taken/target/link result
// with a fetch-flush pulse and a post-redirect stall window. Optional stats: BRANCH_STATS_EN.
module branch_resolve #(
  parameter int unsigned NUM_SIZE     = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                inValid,
  output logic                inReady,
  input  logic                isBranch,
  input  logic                isJal,
  input  logic                isJalr,
  input  logic [2:0]          funct3,
  input  logic                cmpEqual,
  input  logic                cmpLessThan,
  input  logic                cmpLessThanU,
  input  logic [NUM_SIZE-1:0] pc,
  input  logic [NUM_SIZE-1:0] imm,
  input  logic [NUM_SIZE-1:0] rs1,
  output logic                outValid,
  input  logic                outReady,
  output logic                taken,
  output logic [NUM_SIZE-1:0] target,
  output logic [NUM_SIZE-1:0] linkAddr,
  output logic                misaligned,
  output logic                illegal,
  output logic                flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] takenCount,
  output logic [CNT_WIDTH-1:0] branchCount
`endif
);

  localparam int unsigned FcW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e              state_q;
  logic [FcW-1:0]      cnt_q;
  logic                out_valid_q, taken_q, misaligned_q, illegal_q, flush_q;
  logic [NUM_SIZE-1:0] target_q, link_q;

  logic                accept, handshake;
  logic                cond, taken_d, illegal_d, misaligned_d, is_cf;
  logic [NUM_SIZE-1:0] link_d, target_d, jump_d;

  assign inReady   = (state_q == StIdle) && (!out_valid_q || outReady);
  assign accept    = inValid && inReady;
  assign handshake = out_valid_q && outReady;
  assign is_cf     = isBranch || isJal || isJalr;

  always_comb begin
    cond      = 1'b0;
    illegal_d = 1'b0;
    case (funct3)
      3'b000:  cond = cmpEqual;
      3'b001:  cond = !cmpEqual;
      3'b100:  cond = cmpLessThan;
      3'b101:  cond = !cmpLessThan;
      3'b110:  cond = cmpLessThanU;
      3'b111:  cond = !cmpLessThanU;
      default: illegal_d = isBranch && !isJal && !isJalr;
    endcase
  end

  always_comb begin
    link_d  = pc + NUM_SIZE'(4);
    jump_d  = pc + imm;
    taken_d = 1'b0;
    if (isJalr) begin
      taken_d = 1'b1;
      // Bit 0 is cleared before alignment is judged, so only bit 1 can flag misaligned.
      jump_d  = (rs1 + imm) & ~NUM_SIZE'(1);
    end else if (isJal) begin
      taken_d = 1'b1;
    end else if (isBranch) begin
      taken_d = cond;
    end
    target_d     = taken_d ? jump_d : link_d;
    misaligned_d = taken_d && target_d[1];
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      flush_q      <= 1'b0;
      target_q     <= '0;
      link_q       <= '0;
    end else begin
      if (state_q == StFlush) begin
        if (cnt_q == FcW'(1)) state_q <= StIdle;
        cnt_q <= cnt_q - FcW'(1);
      end
      if (accept) begin
        out_valid_q  <= 1'b1;
        taken_q      <= taken_d;
        misaligned_q <= misaligned_d;
        illegal_q    <= illegal_d;
        flush_q      <= taken_d;
        target_q     <= target_d;
        link_q       <= link_d;
        if (taken_d) begin
          state_q <= StFlush;
          cnt_q   <= FcW'(FLUSH_CYCLES);
        end
      end else if (handshake) begin
        // Payload is left as-is; only the valid and the pulse retire.
        out_valid_q <= 1'b0;
        flush_q     <= 1'b0;
      end
    end
  end

  assign outValid   = out_valid_q;
  assign taken      = taken_q;
  assign target     = target_q;
  assign linkAddr   = link_q;
  assign misaligned = misaligned_q;
  assign illegal    = illegal_q;
  assign flush      = flush_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_WIDTH-1:0] taken_cnt_q, branch_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      taken_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else if (accept) begin
      if (is_cf && (branch_cnt_q != '1)) branch_cnt_q <= branch_cnt_q + CNT_WIDTH'(1);
      if (taken_d && (taken_cnt_q != '1)) taken_cnt_q <= taken_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign takenCount  = taken_cnt_q;
  assign branchCount = branch_cnt_q;
`else
  logic unused_cf;
  assign unused_cf = is_cf;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed cases with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_branch_resolve;

  localparam int unsigned FLUSH = 2;

  logic        clk, rstN, inValid, inReady, isBranch, isJal, isJalr;
  logic [2:0]  funct3;
  logic        cmpEqual, cmpLessThan, cmpLessThanU;
  logic [31:0] pc, imm, rs1, target, linkAddr;
  logic        outValid, outReady, taken, misaligned, illegal, flush;
`ifdef BRANCH_STATS_EN
  logic [15:0] takenCount, branchCount;
`endif

  branch_resolve #(.NUM_SIZE(32), .FLUSH_CYCLES(FLUSH), .CNT_WIDTH(16)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
    .isBranch(isBranch), .isJal(isJal), .isJalr(isJalr), .funct3(funct3),
    .cmpEqual(cmpEqual), .cmpLessThan(cmpLessThan), .cmpLessThanU(cmpLessThanU),
    .pc(pc), .imm(imm), .rs1(rs1), .outValid(outValid), .outReady(outReady),
    .taken(taken), .target(target), .linkAddr(linkAddr), .misaligned(misaligned),
    .illegal(illegal), .flush(flush)
`ifdef BRANCH_STATS_EN
    , .takenCount(takenCount), .branchCount(branchCount)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model: expected registered result plus number of cycles inReady is still blocked.
  typedef struct packed {
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] lnk;
    logic        mis;
    logic        ill;
    logic        fl;
  } res_t;

  res_t        m_res;
  bit          m_valid = 1'b0;
  int          m_blocked = 0;
  int unsigned m_bc = 0, m_tc = 0;
  bit          m_rdy, m_acc, m_hs;

  function automatic res_t resolve();
    res_t r;
    bit   conds[8];
    conds = '{cmpEqual, !cmpEqual, 1'b0, 1'b0, cmpLessThan, !cmpLessThan,
              cmpLessThanU, !cmpLessThanU};
    r = '0;
    r.lnk = pc + 32'd4;
    if (isJalr) begin
      r.tk = 1'b1;
      r.tgt = (rs1 + imm) & 32'hFFFF_FFFE;
    end else if (isJal) begin
      r.tk = 1'b1;
      r.tgt = pc + imm;
    end else if (isBranch) begin
      r.tk = conds[funct3];
      r.ill = (funct3 == 3'd2) || (funct3 == 3'd3);
      r.tgt = pc + imm;
    end
    if (!r.tk) r.tgt = r.lnk;
    r.mis = r.tk && r.tgt[1];
    r.fl = r.tk;
    return r;
  endfunction

  always @(posedge clk) begin
    m_rdy = (m_blocked == 0) && (!m_valid || outReady);
    m_acc = inValid && m_rdy;
    m_hs  = m_valid && outReady;
    if (!rstN) begin
      m_valid = 1'b0; m_blocked = 0; m_bc = 0; m_tc = 0; m_res = '0;
    end else begin
      if (m_blocked > 0) m_blocked--;
      if (m_acc) begin
        m_res = resolve();
        m_valid = 1'b1;
        if (m_res.tk) m_blocked = FLUSH;
        if ((isBranch || isJal || isJalr) && m_bc < 65535) m_bc++;
        if (m_res.tk && m_tc < 65535) m_tc++;
      end else if (m_hs) begin
        m_valid = 1'b0;
        m_res.fl = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("inReady", 64'(inReady), 64'((m_blocked == 0) && (!m_valid || outReady)));
      check("outValid", 64'(outValid), 64'(m_valid));
      if (m_valid) begin
        check("taken", 64'(taken), 64'(m_res.tk));
        check("target", 64'(target), 64'(m_res.tgt));
        check("linkAddr", 64'(linkAddr), 64'(m_res.lnk));
        check("misaligned", 64'(misaligned), 64'(m_res.mis));
        check("illegal", 64'(illegal), 64'(m_res.ill));
        check("flush", 64'(flush), 64'(m_res.fl));
      end else begin
        check("flush_idle", 64'(flush), 64'd0);
      end
`ifdef BRANCH_STATS_EN
      check("branchCount", 64'(branchCount), 64'(m_bc));
      check("takenCount", 64'(takenCount), 64'(m_tc));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input bit v, input bit b, input bit j, input bit jr, input logic [2:0] f3,
                        input logic [31:0] p, input logic [31:0] im, input logic [31:0] r1);
    inValid = v; isBranch = b; isJal = j; isJalr = jr; funct3 = f3;
    pc = p; imm = im; rs1 = r1;
  endtask

  task automatic randomize_inputs();
    int k;
    k = $urandom_range(0, 7);
    set_op($urandom_range(0, 9) < 6, 1'b0, 1'b0, 1'b0, 3'($urandom), $urandom, 32'h0, $urandom);
    if ($urandom_range(0, 3) == 0) pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    imm = {{20{1'b0}}, 12'($urandom)};
    if (imm[11]) imm[31:12] = '1;
    case (k)
      0, 1, 2: isBranch = 1'b1;
      3:       isJal = 1'b1;
      4:       isJalr = 1'b1;
      6:       {isBranch, isJal, isJalr} = 3'($urandom);
      7:       begin isBranch = 1'b1; funct3 = {2'b01, 1'($urandom)}; end
      default: ;
    endcase
    {cmpEqual, cmpLessThan, cmpLessThanU} = 3'($urandom);
    outReady = $urandom_range(0, 9) < 7;
    rstN = $urandom_range(0, 199) != 0;
  endtask

  initial begin
    rstN = 1'b0; outReady = 1'b1;
    cmpEqual = 1'b0; cmpLessThan = 1'b0; cmpLessThanU = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0);
    cyc();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_outValid", 64'(outValid), 64'd0);
    check("rst_target", 64'(target), 64'd0);
    check("rst_inReady", 64'(inReady), 64'd1);
    cyc();
    rstN = 1'b1;

    // BEQ taken
    set_op(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h20, 32'h0);
    cmpEqual = 1'b1;
    cyc();
    inValid = 1'b0;
    @(negedge clk);
    check("t1_target", 64'(target), 64'h120);
    check("t1_flush", 64'(flush), 64'd1);
    check("t1_inReady0", 64'(inReady), 64'd0);
    cyc();
    @(negedge clk);
    check("t1_inReady1", 64'(inReady), 64'd0);
    cyc();

    // BLTU not taken, then JALR back-to-back
    set_op(1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 32'h200, 32'h40, 32'h0);
    cmpLessThanU = 1'b0;
    cyc();
    set_op(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h40, 32'h4, 32'h1003);
    @(negedge clk);
    check("t2_target", 64'(target), 64'h204);
    check("t2_taken", 64'(taken), 64'd0);
    check("t2_inReady", 64'(inReady), 64'd1);
    cyc();
    inValid = 1'b0;
    @(negedge clk);
    check("t3_target", 64'(target), 64'h1006);
    check("t3_link", 64'(linkAddr), 64'h44);
    check("t3_misaligned", 64'(misaligned), 64'd1);
    cyc();
    cyc();

    // BNE across the address wrap, then a 3-cycle output stall
    set_op(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 32'hFFFF_FFFC, 32'h8, 32'h0);
    cmpEqual = 1'b0;
    cyc();
    inValid = 1'b0;
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_target", 64'(target), 64'h4);
      check("t4_link", 64'(linkAddr), 64'h0);
      check("t5_flush_held", 64'(flush), 64'd1);
      check("t5_inReady", 64'(inReady), 64'd0);
`ifdef BRANCH_STATS_EN
      check("t5_branchCount", 64'(branchCount), 64'd4);
      check("t5_takenCount", 64'(takenCount), 64'd3);
`endif
      cyc();
    end
    outReady = 1'b1;
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h300, 32'h0, 32'h0);
    @(negedge clk);
    check("t5_accept", 64'(inReady), 64'd1);
    cyc();
    inValid = 1'b0;
    @(negedge clk);
    check("t5_new_target", 64'(target), 64'h304);
    check("t5_new_flush", 64'(flush), 64'd0);

    // Reset during the flush window
    set_op(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h500, 32'h10, 32'h0);
    cmpEqual = 1'b1;
    cyc();
    inValid = 1'b0;
    rstN = 1'b0;
    cyc();
    rstN = 1'b1;
    @(negedge clk);
    check("t6_outValid", 64'(outValid), 64'd0);
    check("t6_flush", 64'(flush), 64'd0);
    check("t6_inReady", 64'(inReady), 64'd1);

    for (int n = 0; n < 4000; n++) begin
      randomize_inputs();
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
